// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared types and helpers for the parametrised synchronous FIFO.
//   fifo_state_t : occupancy state of the FIFO controller (EMPTY / MID / FULL)
//   fifo_cw()    : width of an occupancy count able to hold 0..depth inclusive
// -----------------------------------------------------------------------------
package fifo_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      MID   = 2'd1,
      FULL  = 2'd2
   } fifo_state_t;

   // One bit wider than the pointer so that a completely full FIFO
   // (count == depth) is representable.
   function automatic int fifo_cw(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem_dp.sv
// -----------------------------------------------------------------------------
// fifo_mem_dp
// Storage array for the FIFO: one synchronous write port, one asynchronous
// read port. Contents are never reset, so a FIFO clear leaves stale data
// in place (it is simply no longer addressable as valid).
// Ports:
//   CLOCK    in   clock, write on rising edge
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module fifo_mem_dp
   import fifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 32
) (
   input  logic                     CLOCK,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge CLOCK) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : fifo_mem_dp

// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// flags, sticky overflow/underflow bits and optional first-word-fall-through.
// Ports:
//   CLOCK       in   clock, rising edge
//   RESET_N     in   asynchronous active-low reset
//   CLEAR_N     in   synchronous active-low clear (beats WRITE/READ)
//   WRITE       in   write request
//   READ        in   read request
//   DATA_IN     in   write data
//   DATA_OUT    out  read data (registered, or fall-through when FWFT=1)
//   F_FULL_N    out  low when count == DEPTH
//   F_EMPTY_N   out  low when count == 0
//   F_AFULL_N   out  low when count >= AF_LEVEL
//   F_AEMPTY_N  out  low when count <= AE_LEVEL
//   USE_DW      out  occupancy 0..DEPTH
//   OVERFLOW    out  sticky: a write was rejected
//   UNDERFLOW   out  sticky: a read was rejected
// -----------------------------------------------------------------------------
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 32,
   parameter int AF_LEVEL = DEPTH - 4,
   parameter int AE_LEVEL = 4,
   parameter int FWFT     = 0
) (
   input  logic                   CLOCK,
   input  logic                   RESET_N,
   input  logic                   CLEAR_N,
   input  logic                   WRITE,
   input  logic                   READ,
   input  logic [WIDTH-1:0]       DATA_IN,
   output logic [WIDTH-1:0]       DATA_OUT,
   output logic                   F_FULL_N,
   output logic                   F_EMPTY_N,
   output logic                   F_AFULL_N,
   output logic                   F_AEMPTY_N,
   output logic [$clog2(DEPTH):0] USE_DW,
   output logic                   OVERFLOW,
   output logic                   UNDERFLOW
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = fifo_cw(DEPTH);

   // ---------------------------------------------------------------- checks
   if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
      $error("fifo_sync_param: DEPTH must be a power of two and at least 4");
   end
   if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_chk_levels
      $error("fifo_sync_param: require AE_LEVEL < AF_LEVEL <= DEPTH");
   end

   // ---------------------------------------------------------------- state
   fifo_state_t      state_q, state_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full_n_q, empty_n_q, afull_n_q, aempty_n_q;
   logic             overflow_q, underflow_q;

   logic             is_full, is_empty;
   logic             wr_acc, rd_acc;
   logic             mem_we;
   logic [WIDTH-1:0] mem_rdata;

   // State register
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= EMPTY;
      end else if (!CLEAR_N) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; only accepted operations move the FSM
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: begin
            if (wr_acc) state_d = MID;
         end
         MID: begin
            if (wr_acc && !rd_acc && (count_q == CW'(DEPTH - 1)))
               state_d = FULL;
            else if (rd_acc && !wr_acc && (count_q == CW'(1)))
               state_d = EMPTY;
         end
         FULL: begin
            if (rd_acc && !wr_acc) state_d = MID;
         end
         default: state_d = EMPTY;
      endcase
   end

   // Output decode from state: acceptance of the current requests.
   // When full, a write is only taken if a read frees a slot on the same edge.
   always_comb begin
      is_full  = (state_q == FULL);
      is_empty = (state_q == EMPTY);
      wr_acc   = WRITE && (!is_full || READ);
      rd_acc   = READ && !is_empty;
   end

   // ---------------------------------------------------------------- datapath
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Flags are derived from the next count so they line up with USE_DW
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_n_q    <= 1'b1;
         empty_n_q   <= 1'b0;
         afull_n_q   <= 1'b1;
         aempty_n_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (!CLEAR_N) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_n_q    <= 1'b1;
         empty_n_q   <= 1'b0;
         afull_n_q   <= 1'b1;
         aempty_n_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_n_q    <= (count_d != CW'(DEPTH));
         empty_n_q   <= (count_d != '0);
         afull_n_q   <= (count_d <  CW'(AF_LEVEL));
         aempty_n_q  <= (count_d >  CW'(AE_LEVEL));
         overflow_q  <= overflow_q  | (WRITE && !wr_acc);
         underflow_q <= underflow_q | (READ  && !rd_acc);
      end
   end

   // A write coinciding with a clear is dropped, so it must not touch memory
   assign mem_we = wr_acc && CLEAR_N;

   fifo_mem_dp #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .CLOCK   (CLOCK),
      .we_i    (mem_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (DATA_IN),
      .raddr_i (rd_ptr_q),
      .rdata_o (mem_rdata)
   );

   // ---------------------------------------------------------------- read data
   if (FWFT == 0) begin : g_reg_read
      logic [WIDTH-1:0] dout_q;
      always_ff @(posedge CLOCK or negedge RESET_N) begin
         if (!RESET_N) begin
            dout_q <= '0;
         end else if (!CLEAR_N) begin
            dout_q <= '0;
         end else if (rd_acc) begin
            dout_q <= mem_rdata;
         end
      end
      assign DATA_OUT = dout_q;
   end else begin : g_fwft_read
      // Head word shown directly; forced to zero while empty so stale
      // memory contents never leak out.
      assign DATA_OUT = empty_n_q ? mem_rdata : '0;
   end

   assign F_FULL_N   = full_n_q;
   assign F_EMPTY_N  = empty_n_q;
   assign F_AFULL_N  = afull_n_q;
   assign F_AEMPTY_N = aempty_n_q;
   assign USE_DW     = count_q;
   assign OVERFLOW   = overflow_q;
   assign UNDERFLOW  = underflow_q;

endmodule : fifo_sync_param
